// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, type-field position and
// the packet framing states used by the input and output flow control.
package noc_pkg;

    localparam int FLIT_TYPE_BITS = 2;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_PKT  = 1'b1
    } frame_state_e;

    // The type field sits in the top FLIT_TYPE_BITS of every flit.
    function automatic int flit_type_lsb(input int flit_width);
        return flit_width - FLIT_TYPE_BITS;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// First-word-fall-through flit buffer with wrapping pointers and an
// occupancy counter; a write is never visible on dout in the same cycle.
module noc_fifo #(
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [FLIT_WIDTH-1:0]      din,
    input  logic                       rd_en,
    output logic [FLIT_WIDTH-1:0]      dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  do_wr;
    logic                  do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_COUNT);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/input_flow_control.sv
// Router input port: return/ready generation toward upstream plus a packet
// framing checker that drops out-of-order flits and flags them on pkt_err.
module input_flow_control
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       val,
    input  logic [FLIT_WIDTH-1:0]      din,
    output logic                       ret,
    input  logic                       rd_en,
    output logic [FLIT_WIDTH-1:0]      dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       pkt_err
);

    localparam int TYPE_LSB = flit_type_lsb(FLIT_WIDTH);

    frame_state_e state;
    frame_state_e next_state;
    flit_type_e   ftype;
    logic         accepted;
    logic         frame_ok;
    logic         fifo_wr;

    // ret comes straight from registered occupancy, never from val/rd_en.
    assign ret      = !full;
    assign accepted = val && ret;
    assign ftype    = flit_type_e'(din[TYPE_LSB +: FLIT_TYPE_BITS]);
    assign fifo_wr  = accepted && frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FRAME_IDLE;
            pkt_err <= 1'b0;
        end else begin
            state   <= next_state;
            pkt_err <= accepted && !frame_ok;
        end
    end

    // Only accepted flits advance the framing state; bad ones leave it alone.
    always_comb begin
        next_state = state;
        frame_ok   = 1'b0;
        case (state)
            FRAME_IDLE: begin
                if (ftype == FLIT_HEAD) begin
                    frame_ok   = 1'b1;
                    next_state = FRAME_PKT;
                end else if (ftype == FLIT_SINGLE) begin
                    frame_ok = 1'b1;
                end
            end
            FRAME_PKT: begin
                if (ftype == FLIT_BODY) begin
                    frame_ok = 1'b1;
                end else if (ftype == FLIT_TAIL) begin
                    frame_ok   = 1'b1;
                    next_state = FRAME_IDLE;
                end
            end
            default: next_state = FRAME_IDLE;
        endcase
        if (!accepted) begin
            next_state = state;
        end
    end

    noc_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (fifo_wr),
        .din   (din),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_input_flow_control.sv
// Self-checking bench for input_flow_control: directed scenarios followed by
// random traffic, all compared against a queue-based packet-framing model.
module tb_input_flow_control;

    localparam int W  = 34;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          val;
    logic [W-1:0]  din;
    logic          ret;
    logic          rd_en;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          pkt_err;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [W-1:0] modelQ[$];
    bit           modelInPkt;
    bit           modelErr;

    input_flow_control #(.FLIT_WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .val     (val),
        .din     (din),
        .ret     (ret),
        .rd_en   (rd_en),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .pkt_err (pkt_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mkFlit(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("count", 64'(count), 64'(modelQ.size()));
        checkOutput("empty", 64'(empty), 64'(modelQ.size() == 0));
        checkOutput("full", 64'(full), 64'(modelQ.size() == D));
        checkOutput("ret", 64'(ret), 64'(modelQ.size() < D));
        checkOutput("pkt_err", 64'(pkt_err), 64'(modelErr));
        if (modelQ.size() > 0) begin
            checkOutput("dout", 64'(dout), 64'(modelQ[0]));
        end
    endtask

    // One clock of stimulus: check current outputs, drive, clock, update model.
    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
        int  n;
        bit  ready;
        bit  pop;
        bit  acc;
        bit  ok;
        logic [1:0] t;
        checkModel();
        val   = v;
        din   = d;
        rd_en = r;
        rst   = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            modelQ.delete();
            modelInPkt = 0;
            modelErr   = 0;
        end else begin
            n     = modelQ.size();
            ready = n < D;
            pop   = r && n > 0;
            acc   = v && ready;
            t     = d[W-1:W-2];
            ok    = modelInPkt ? (t == T_BODY || t == T_TAIL) : (t == T_HEAD || t == T_SINGLE);
            modelErr = acc && !ok;
            if (pop) void'(modelQ.pop_front());
            if (acc && ok) begin
                modelQ.push_back(d);
                modelInPkt = (t == T_HEAD) || (t == T_BODY);
            end
        end
        val   = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [1:0] rt;
        rst   = 1'b1;
        val   = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelQ.delete();
        modelInPkt = 0;
        modelErr   = 0;

        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_empty", 64'(empty), 64'd1);
        checkOutput("reset_full", 64'(full), 64'd0);
        checkOutput("reset_ret", 64'(ret), 64'd1);
        checkOutput("reset_pkt_err", 64'(pkt_err), 64'd0);

        // Three-flit packet stored, then popped in order.
        applyStimulus(1, mkFlit(T_HEAD, 32'h0000AAAA), 0, 0);
        applyStimulus(1, mkFlit(T_BODY, 32'h0000BBBB), 0, 0);
        applyStimulus(1, mkFlit(T_TAIL, 32'h0000CCCC), 0, 0);
        checkOutput("pkt3_count", 64'(count), 64'd3);
        checkOutput("pkt3_head", 64'(dout), 64'h1_0000AAAA);
        applyStimulus(0, '0, 1, 0);
        checkOutput("pkt3_body", 64'(dout), 64'h0_0000BBBB);
        applyStimulus(0, '0, 1, 0);
        checkOutput("pkt3_tail", 64'(dout), 64'h2_0000CCCC);
        applyStimulus(0, '0, 1, 0);
        checkOutput("pkt3_empty", 64'(empty), 64'd1);

        // Five back-to-back flits into a four-entry buffer.
        applyStimulus(1, mkFlit(T_HEAD, 32'h11), 0, 0);
        applyStimulus(1, mkFlit(T_BODY, 32'h22), 0, 0);
        applyStimulus(1, mkFlit(T_BODY, 32'h33), 0, 0);
        applyStimulus(1, mkFlit(T_BODY, 32'h44), 0, 0);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_ret", 64'(ret), 64'd0);
        applyStimulus(1, mkFlit(T_TAIL, 32'h55), 0, 0);
        checkOutput("fill_held_count", 64'(count), 64'd4);

        // Full with simultaneous pop and offer: only the pop happens.
        applyStimulus(1, mkFlit(T_TAIL, 32'h55), 1, 0);
        checkOutput("fullpop_count", 64'(count), 64'd3);
        checkOutput("fullpop_ret", 64'(ret), 64'd1);
        checkOutput("fullpop_dout", 64'(dout), 64'h0_00000022);
        applyStimulus(1, mkFlit(T_TAIL, 32'h55), 0, 0);
        checkOutput("refill_count", 64'(count), 64'd4);
        repeat (4) applyStimulus(0, '0, 1, 0);

        // Pop on empty is ignored.
        applyStimulus(0, '0, 1, 0);
        checkOutput("emptypop_count", 64'(count), 64'd0);
        checkOutput("emptypop_empty", 64'(empty), 64'd1);

        // Framing violations.
        applyStimulus(1, mkFlit(T_BODY, 32'h1), 0, 0);
        checkOutput("idle_body_count", 64'(count), 64'd0);
        checkOutput("idle_body_err", 64'(pkt_err), 64'd1);
        applyStimulus(1, mkFlit(T_HEAD, 32'h2), 0, 0);
        checkOutput("idle_body_err_clear", 64'(pkt_err), 64'd0);
        applyStimulus(1, mkFlit(T_SINGLE, 32'h3), 0, 0);
        checkOutput("pkt_single_err", 64'(pkt_err), 64'd1);
        checkOutput("pkt_single_count", 64'(count), 64'd1);
        applyStimulus(1, mkFlit(T_BODY, 32'h4), 0, 0);
        checkOutput("still_pkt_err", 64'(pkt_err), 64'd0);
        checkOutput("still_pkt_count", 64'(count), 64'd2);

        // Reset with two flits buffered mid-packet, racing an offered flit.
        applyStimulus(1, mkFlit(T_BODY, 32'h5), 1, 1);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_ret", 64'(ret), 64'd1);
        applyStimulus(1, mkFlit(T_BODY, 32'h6), 0, 0);
        checkOutput("rst_idle_err", 64'(pkt_err), 64'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rt = 2'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 2) != 0), mkFlit(rt, $urandom()),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
        end
        checkModel();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
